// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers for the inverse cipher.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [127:0] aes_block_t;
  typedef logic [3:0]   aes_kidx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } inv_ctrl_state_t;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero without a special case.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] x2, x4, x8, x16, x32, x64, x128;
    x2   = gmul(a, a);
    x4   = gmul(x2, x2);
    x8   = gmul(x4, x4);
    x16  = gmul(x8, x8);
    x32  = gmul(x16, x16);
    x64  = gmul(x32, x32);
    x128 = gmul(x64, x64);
    return gmul(gmul(gmul(x2, x4), gmul(x8, x16)), gmul(gmul(x32, x64), x128));
  endfunction

  // Inverse S-box: undo the affine transform, then invert in the field.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return ginv(t);
  endfunction

endpackage

// File: rtl/addRoundKey.sv
// AddRoundKey: bitwise XOR of the state with the round key.
module addRoundKey (
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  output logic [127:0] state_out
);

  assign state_out = state_in ^ round_key;

endmodule

// File: rtl/aes_inv_round.sv
// One combinational inverse round; last_round skips InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  aes_block_t state_in,
  input  aes_block_t round_key,
  input  logic       last_round,
  output aes_block_t state_out
);

  aes_block_t shifted;
  aes_block_t subbed;
  aes_block_t keyed;
  aes_block_t mixed;

  inv_shiftRows  u_shift (.state_in(state_in), .state_out(shifted));
  inv_subBytes   u_sub   (.state_in(shifted),  .state_out(subbed));
  addRoundKey    u_ark   (.state_in(subbed),   .round_key(round_key), .state_out(keyed));
  inv_mixColumns u_mix   (.state_in(keyed),    .state_out(mixed));

  assign state_out = last_round ? keyed : mixed;

endmodule

// File: rtl/inv_mixColumns.sv
// InvMixColumns: each column multiplied by the {0e,0b,0d,09} circulant matrix.
module inv_mixColumns
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  output logic [127:0] state_out
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = state_in[127-32*c -: 8];
    assign a1 = state_in[119-32*c -: 8];
    assign a2 = state_in[111-32*c -: 8];
    assign a3 = state_in[103-32*c -: 8];
    assign state_out[127-32*c -: 8] =
      gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
    assign state_out[119-32*c -: 8] =
      gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
    assign state_out[111-32*c -: 8] =
      gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
    assign state_out[103-32*c -: 8] =
      gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
  end

endmodule

// File: rtl/inv_shiftRows.sv
// InvShiftRows: row r rotates right by r columns (column-major byte order).
module inv_shiftRows
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  output logic [127:0] state_out
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign state_out[127-8*(4*c+r) -: 8] = state_in[127-8*(4*((c-r+4)%4)+r) -: 8];
    end
  end

endmodule

// File: rtl/inv_subBytes.sv
// InvSubBytes: inverse S-box applied to each of the 16 state bytes.
module inv_subBytes
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  output logic [127:0] state_out
);

  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign state_out[127-8*i -: 8] = inv_sbox(state_in[127-8*i -: 8]);
  end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES-128 decryption controller: one inverse round per clock,
// round keys fetched by index from an external combinational key store.
module aes_inv_cipher_ctrl
  import aes_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [127:0]      cipher_in,
  input  logic              abort,
  output logic [KIDX_W-1:0] key_idx,
  input  logic [127:0]      round_key,
  output logic              busy,
  output logic              done,
  output logic [127:0]      plain_out
);

  inv_ctrl_state_t state_q, state_d;
  aes_kidx_t       round_cnt_q, round_cnt_d;
  aes_block_t      state_reg_q, state_reg_d;
  aes_block_t      plain_q, plain_d;
  aes_block_t      round_out;
  aes_kidx_t       kidx;
  logic            last_round;
  logic            accept;
  logic            cnt_valid;

  // A block is taken from IDLE or DONE; abort always blocks acceptance.
  assign accept    = start && !abort && (state_q == IDLE || state_q == DONE);
  assign cnt_valid = (round_cnt_q != '0) && (round_cnt_q <= aes_kidx_t'(NR - 1));

  // FSM state register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  // NOTE: defaulting every comb output first keeps all paths assigned, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = ROUND;
        ROUND: begin
          if (!cnt_valid)                          state_d = IDLE;
          else if (round_cnt_q == aes_kidx_t'(1))  state_d = FINAL;
        end
        FINAL:   state_d = DONE;
        DONE:    state_d = start ? ROUND : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: key index decode, status flags and last-round select.
  always_comb begin
    kidx       = aes_kidx_t'(NR);
    busy       = 1'b0;
    done       = 1'b0;
    last_round = 1'b0;
    case (state_q)
      ROUND: begin
        kidx = round_cnt_q;
        busy = 1'b1;
      end
      FINAL: begin
        kidx       = '0;
        busy       = 1'b1;
        last_round = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign key_idx = KIDX_W'(kidx);

  aes_inv_round u_round (
    .state_in  (state_reg_q),
    .round_key (round_key),
    .last_round(last_round),
    .state_out (round_out)
  );

  // Datapath next values: round counter, working state and plaintext.
  always_comb begin
    round_cnt_d = round_cnt_q;
    state_reg_d = state_reg_q;
    plain_d     = plain_q;
    if (abort) begin
      round_cnt_d = '0;
    end else if (accept) begin
      state_reg_d = cipher_in ^ round_key;
      round_cnt_d = aes_kidx_t'(NR - 1);
    end else begin
      case (state_q)
        ROUND: begin
          state_reg_d = round_out;
          if (round_cnt_q != aes_kidx_t'(1)) round_cnt_d = round_cnt_q - aes_kidx_t'(1);
        end
        FINAL: begin
          state_reg_d = round_out;
          plain_d     = round_out;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      round_cnt_q <= '0;
      state_reg_q <= '0;
      plain_q     <= '0;
    end else begin
      round_cnt_q <= round_cnt_d;
      state_reg_q <= state_reg_d;
      plain_q     <= plain_d;
    end
  end

  assign plain_out = plain_q;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Directed bench for aes_inv_cipher_ctrl using FIPS-197 vectors and a key-store model.
module tb_aes_inv_cipher_ctrl;

  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk;
  logic         n_rst;
  logic         start;
  logic [127:0] cipher_in;
  logic         abort;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic         busy;
  logic         done;
  logic [127:0] plain_out;

  logic [127:0] ks [0:1][0:10];
  int unsigned  key_sel;
  int           checks;
  int           errors;

  aes_inv_cipher_ctrl dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (start),
    .cipher_in(cipher_in),
    .abort    (abort),
    .key_idx  (key_idx),
    .round_key(round_key),
    .busy     (busy),
    .done     (done),
    .plain_out(plain_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational key store.
  always_comb begin
    round_key = '0;
    if (key_idx <= 4'd10) round_key = ks[key_sel][key_idx];
  end

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box via brute-force field inverse and the affine map.
  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (x != 8'h00 && tb_gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  task automatic expand_key(input logic [127:0] key, input int sel);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])}
            ^ {rcon, 24'h0};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ks[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one block from idle; optionally pulse start with another block at E+poke_at.
  task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] pt,
                           input int poke_at);
    start = 1'b1;
    cipher_in = ct;
    check({tag, "_kidx_idle"}, 128'(key_idx), 128'd10);
    tick();
    start = 1'b0;
    cipher_in = '0;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("%s_kidx_%0d", tag, k), 128'(key_idx), (k < 9) ? 128'(9 - k) : 128'd0);
      check($sformatf("%s_busy_%0d", tag, k), 128'(busy), 128'd1);
      check($sformatf("%s_done_%0d", tag, k), 128'(done), 128'd0);
      if (poke_at > 0 && k == poke_at - 1) begin
        start = 1'b1;
        cipher_in = CT_B;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check({tag, "_done"},  128'(done), 128'd1);
    check({tag, "_busy"},  128'(busy), 128'd0);
    check({tag, "_plain"}, plain_out, pt);
    check({tag, "_kidx_done"}, 128'(key_idx), 128'd10);
    tick();
    check({tag, "_done_pulse"}, 128'(done), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    int seen;
    checks = 0;
    errors = 0;
    n_rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cipher_in = '0;
    key_sel = 0;
    expand_key(KEY_A, 0);
    expand_key(KEY_B, 1);

    // Reset state and idle key index.
    #3;
    check("rst_busy",  128'(busy), 128'd0);
    check("rst_done",  128'(done), 128'd0);
    check("rst_plain", plain_out, 128'd0);
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_kidx", 128'(key_idx), 128'd10);
      check("idle_busy", 128'(busy), 128'd0);
      check("idle_done", 128'(done), 128'd0);
    end

    // FIPS-197 C.1 decryption.
    run_block("c1", CT_A, PT_A, 0);

    // Asynchronous reset mid-ROUND (round_cnt = 5).
    start = 1'b1;
    cipher_in = CT_A;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid_kidx", 128'(key_idx), 128'd5);
    #2;
    n_rst = 1'b0;
    #1;
    check("arst_busy",  128'(busy), 128'd0);
    check("arst_done",  128'(done), 128'd0);
    check("arst_plain", plain_out, 128'd0);
    check("arst_kidx",  128'(key_idx), 128'd10);
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    run_block("post_rst", CT_A, PT_A, 0);

    // Back-to-back blocks with start held high.
    key_sel = 0;
    start = 1'b1;
    cipher_in = CT_A;
    tick();
    cipher_in = CT_B;
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("b2b_lat", 128'(n), 128'd10);
    check("b2b_plain_a", plain_out, PT_A);
    key_sel = 1;
    tick();
    start = 1'b0;
    check("b2b_accept", 128'(busy), 128'd1);
    n = 1;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("b2b_gap", 128'(n), 128'd11);
    check("b2b_plain_b", plain_out, PT_B);
    tick();
    check("b2b_end_done", 128'(done), 128'd0);
    check("b2b_end_busy", 128'(busy), 128'd0);

    // start while busy is ignored.
    key_sel = 0;
    run_block("ign", CT_A, PT_A, 4);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) seen++;
    end
    check("ign_no_extra_done", 128'(seen), 128'd0);

    // Abort at E+6 with a block whose result would differ.
    key_sel = 1;
    start = 1'b1;
    cipher_in = CT_B;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_kidx", 128'(key_idx), 128'd10);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) seen++;
      tick();
    end
    check("abort_no_done", 128'(seen), 128'd0);
    check("abort_plain", plain_out, PT_A);
    abort = 1'b1;
    start = 1'b1;
    tick();
    check("abort_start_busy", 128'(busy), 128'd0);
    abort = 1'b0;
    start = 1'b0;
    tick();
    check("abort_start_busy2", 128'(busy), 128'd0);
    check("abort_start_done", 128'(done), 128'd0);

    // Recovery after abort with the FIPS-197 B vector.
    run_block("fipsb", CT_B, PT_B, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
